iddr_line_responder: RTL

- Memory-side responder for the instruction cache refill interface.
- Accepts a cacheline read request (icache_iddr_addr/icache_iddr_read) and fetches the line as a sequence of word reads from a word-wide memory port with variable latency.
- Assembles the beats into one cacheline register and returns it with a single-cycle iddr_icache_resp.
- Sits between icache and the instruction-side memory/DDR word interface.

---
 rtl/iddr_line_responder.sv | 104 ++++++++++
 1 files changed

// File: rtl/iddr_line_responder.sv
// Instruction-side line refill responder: fetches a cacheline as word beats.
// Optional wrap-around beat order with IDDR_CRITICAL_WORD_FIRST_EN.
module iddr_line_responder #(
  parameter int line_size_bytes = 16,
  parameter int word_size_bytes = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  icache_iddr_addr,
  input  logic                         icache_iddr_read,
  output logic [line_size_bytes*8-1:0] iddr_icache_rdata,
  output logic                         iddr_icache_resp,
  output logic [31:0]                  mem_addr,
  output logic                         mem_read,
  input  logic [word_size_bytes*8-1:0] mem_rdata,
  input  logic                         mem_resp
);

  localparam int W    = word_size_bytes * 8;
  localparam int WPL  = line_size_bytes / word_size_bytes;
  localparam int OFF  = $clog2(line_size_bytes);
  localparam int WOFF = $clog2(word_size_bytes);
  localparam int IW   = OFF - WOFF;

  localparam logic [IW-1:0] LAST = IW'(WPL - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [31:0]   MASK = ~((32'd1 << OFF) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] beat;
  logic [IW-1:0] start;
  logic [31:0]   base;
  logic [IW-1:0] idx;
  logic [IW-1:0] nidx;
  logic [IW-1:0] req_start;
  logic [31:0]   req_base;
  logic          unused_addr;

  // Index arithmetic is IW bits wide, so it wraps inside the line.
  assign idx      = start + beat;
  assign nidx     = idx + ONE;
  assign req_base = icache_iddr_addr & MASK;

`ifdef IDDR_CRITICAL_WORD_FIRST_EN
  assign req_start = icache_iddr_addr[OFF-1:WOFF];
`else
  assign req_start = '0;
`endif

  assign unused_addr = ^icache_iddr_addr[OFF-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      beat              <= '0;
      start             <= '0;
      base              <= '0;
      iddr_icache_rdata <= '0;
      iddr_icache_resp  <= 1'b0;
      mem_read          <= 1'b0;
      mem_addr          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          iddr_icache_resp <= 1'b0;
          mem_read         <= 1'b0;
          if (icache_iddr_read) begin
            base     <= req_base;
            start    <= req_start;
            beat     <= '0;
            mem_read <= 1'b1;
            mem_addr <= req_base | (32'(req_start) << WOFF);
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (mem_resp) begin
            iddr_icache_rdata[idx*W +: W] <= mem_rdata;
            beat <= beat + ONE;
            if (beat == LAST) begin
              mem_read         <= 1'b0;
              iddr_icache_resp <= 1'b1;
              state            <= RESP;
            end else begin
              mem_addr <= base | (32'(nidx) << WOFF);
            end
          end
        end
        RESP: begin
          iddr_icache_resp <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
